// File: rtl/aes_128_key_expand_wr.sv
// AES-128 key-schedule engine feeding the round-key RAM write port.
// Expands one cipher key into 22 RAM words across two ping-pong buffers.
module aes_128_key_expand_wr #(
    parameter int BUF1_BASE     = 22,
    parameter int WORDS_PER_KEY = 22
) (
    input  logic         clk,
    input  logic         kill,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         en_wr,
    output logic [5:0]   addr_wr,
    output logic [63:0]  key_round_wr,
    input  logic [1:0]   buf_release,
    output logic [1:0]   key_buf_valid,
    output logic         key_done,
    output logic         key_done_buf
);

    localparam logic [5:0] BASE1    = 6'(BUF1_BASE);
    localparam logic [3:0] LAST_RND = 4'(WORDS_PER_KEY / 2 - 1);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        RND_LO,
        RND_HI,
        DONE
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t       state, state_n;
    logic         wr_sel, wr_sel_n;
    logic [127:0] rk, rk_n;
    logic [3:0]   round, round_n;
    logic         en_n;
    logic [5:0]   addr_n;
    logic [63:0]  data_n;
    logic [1:0]   valid_n;
    logic         done_n;
    logic         done_buf_n;

    logic [5:0]   base;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot, sub;
    logic [31:0]  w4, w5, w6, w7;
    logic [127:0] nk;

    assign base = wr_sel ? BASE1 : 6'd0;

    assign key_ready = (state == IDLE) && !key_buf_valid[wr_sel] && !kill;

    // Next round key from the held round key; words packed little-endian.
    always_comb begin
        w0  = rk[31:0];
        w1  = rk[63:32];
        w2  = rk[95:64];
        w3  = rk[127:96];
        rot = {w3[7:0], w3[31:8]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]),
               sbox(rot[15:8]),  sbox(rot[7:0])};
        w4  = w0 ^ sub ^ {24'd0, rcon(round)};
        w5  = w4 ^ w1;
        w6  = w5 ^ w2;
        w7  = w6 ^ w3;
        nk  = {w7, w6, w5, w4};
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_n    = state;
        wr_sel_n   = wr_sel;
        rk_n       = rk;
        round_n    = round;
        en_n       = 1'b0;
        addr_n     = addr_wr;
        data_n     = key_round_wr;
        valid_n    = key_buf_valid & ~buf_release;
        done_n     = 1'b0;
        done_buf_n = key_done_buf;
        unique case (state)
            IDLE: begin
                if (key_valid && key_ready) begin
                    rk_n    = key_in;
                    en_n    = 1'b1;
                    addr_n  = base;
                    data_n  = key_in[63:0];
                    state_n = LOAD_HI;
                end
            end
            LOAD_HI: begin
                en_n    = 1'b1;
                addr_n  = addr_wr + 6'd1;
                data_n  = rk[127:64];
                round_n = 4'd1;
                state_n = RND_LO;
            end
            RND_LO: begin
                en_n    = 1'b1;
                addr_n  = addr_wr + 6'd1;
                data_n  = nk[63:0];
                rk_n    = nk;
                state_n = RND_HI;
            end
            RND_HI: begin
                en_n   = 1'b1;
                addr_n = addr_wr + 6'd1;
                data_n = rk[127:64];
                if (round == LAST_RND) begin
                    state_n = DONE;
                end else begin
                    round_n = round + 4'd1;
                    state_n = RND_LO;
                end
            end
            DONE: begin
                done_n          = 1'b1;
                done_buf_n      = wr_sel;
                valid_n[wr_sel] = 1'b1;
                wr_sel_n        = ~wr_sel;
                state_n         = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; kill aborts any expansion in progress.
    always_ff @(posedge clk) begin
        if (kill) begin
            state         <= IDLE;
            wr_sel        <= 1'b0;
            rk            <= '0;
            round         <= 4'd0;
            en_wr         <= 1'b0;
            addr_wr       <= 6'd0;
            key_round_wr  <= 64'd0;
            key_buf_valid <= 2'b00;
            key_done      <= 1'b0;
            key_done_buf  <= 1'b0;
        end else begin
            state         <= state_n;
            wr_sel        <= wr_sel_n;
            rk            <= rk_n;
            round         <= round_n;
            en_wr         <= en_n;
            addr_wr       <= addr_n;
            key_round_wr  <= data_n;
            key_buf_valid <= valid_n;
            key_done      <= done_n;
            key_done_buf  <= done_buf_n;
        end
    end

endmodule

// File: doc/aes_128_key_expand_wr.md
Name: aes_128_key_expand_wr

Overview:
AES-128 key-schedule engine that sits directly upstream of the 64x64 round-key RAM. It accepts a 128-bit cipher key over a valid/ready handshake and expands it into 11 round keys (22 64-bit words). It writes those words through the RAM write port into one of two ping-pong buffers: buffer 0 at addresses 0..21, buffer 1 at addresses 22..43. It tracks buffer ownership so the round datapath never reads a buffer that is being rewritten.

Parameters:
BUF1_BASE, 22, base write address of buffer 1 (buffer 0 base fixed at 0)
WORDS_PER_KEY, 22, 64-bit words written per expansion (11 round keys x 2)

Ports:
clk  input  1  single clock, all logic on rising edge
kill  input  1  synchronous active-high reset
key_valid  input  1  key_in valid
key_ready  output  1  engine can accept a key
key_in  input  128  cipher key; key_in[7:0] = key byte 0, key_in[127:120] = byte 15
en_wr  output  1  RAM write enable
addr_wr  output  6  RAM write address
key_round_wr  output  64  RAM write data
buf_release  input  2  one-cycle pulse per bit; consumer frees buffer i
key_buf_valid  output  2  bit i = buffer i holds a complete schedule, owned by consumer
key_done  output  1  one-cycle pulse when a schedule completes
key_done_buf  output  1  buffer index for key_done, held until next key_done

Behaviour:
- Reset: kill high at a clock edge gives state IDLE, wr_sel=0, en_wr=0, addr_wr=0, key_round_wr=0, key_buf_valid=00, key_done=0, key_done_buf=0, key_ready=0 in the cycle after reset.
- Reset mid-expansion: abort immediately. A partially written buffer stays invalid. No further writes occur.
- All write-port outputs, key_done and key_buf_valid are registered.
- key_ready = (state==IDLE) && !key_buf_valid[wr_sel] && !kill-cycle. Handshake occurs when key_valid && key_ready at an edge; key_in is latched.
- Word format: 32-bit schedule word w[i] packs its bytes little-endian (first byte at [7:0]). RAM word 2r = {w[4r+1], w[4r]}, RAM word 2r+1 = {w[4r+3], w[4r+2]}, for r = 0..10.
- States: IDLE, LOAD_HI, RND_LO, RND_HI, DONE.
- Accepting edge (IDLE): present word 0 (key_in[63:0]) at base+0 on the next cycle.
- LOAD_HI: write word 1 (key[127:64]) at base+1.
- RND_LO: combinationally compute the next round key from the held round key: w4 = w0^SubWord(RotWord(w3))^Rcon, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3. Write {w5,w4}. Register the full new key.
- RND_HI: write {w7,w6}. If round==10 go to DONE, else go to RND_LO with round+1.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36, applied to the least-significant byte of the packed word.
- SubWord uses the FIPS-197 S-box. Implementation is combinational, either table or composite-field; no extra cycle.
- Write sequence: en_wr high for exactly 22 consecutive cycles, starting the cycle after the accepting edge. addr_wr runs base..base+21 ascending with no gaps. base = 0 if wr_sel=0, BUF1_BASE if wr_sel=1.
- DONE (1 cycle, the cycle after the last write): key_done=1, key_done_buf=wr_sel, key_buf_valid[wr_sel] set, wr_sel toggles, return to IDLE.
- Throughput: accepting edge to key_done is 23 cycles. The next key is accepted at the earliest 1 cycle after key_done, provided the new wr_sel buffer is free.
- buf_release[i] clears key_buf_valid[i] on the next edge.
- buf_release on an already-invalid buffer is ignored.
- buf_release on the buffer being written cannot conflict: that buffer is invalid by construction, so the release is ignored.
- Release and set on different buffers in the same cycle are both honoured.
- Both buffers valid: key_ready stays 0 until the buffer at wr_sel is released.
- key_valid dropped while key_ready=0 has no effect. No key is buffered beyond key_in.

Test Plan:
- FIPS key 000102..0f (key_in=128'h0f0e0d0c0b0a09080706050403020100) after reset:
  - addresses 0..21 written in order
  - word0=64'h0706050403020100, word2=64'hfa72afd2fd74aad6, word4=64'hf1bd3d640bcf92b6, word21=64'hc5302b4d8ba707f3
  - key_done at cycle 23 with key_done_buf=0, key_buf_valid=01
- Second key, same value, sent immediately: writes go to 22..43 with word at 43 = 64'hc5302b4d8ba707f3. Then key_buf_valid=11, key_ready=0.
- Third key with both buffers valid: no writes. Pulse buf_release=01, then key accepted next cycle and written to 0..21.
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c (key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b):
  - word20=64'h8925eec9a8f914d0
  - word21=64'ha60c63b6c80c3fe1
- kill asserted at write 10:
  - en_wr low from the next cycle
  - key_buf_valid=00, wr_sel=0, no key_done
  - the next key rewrites addresses 0..21 fully
- buf_release=10 while only buffer 0 is valid: no change. buf_release=01 and key_done for buffer 1 in the same cycle: key_buf_valid=10.
